sort_iter_minmax_sched: RTL and testbench

- Iterative 4-element sorter with one shared combinational min/max unit.
- A scheduler FSM walks a fixed 5-step compare-swap network through that unit, one step per cycle.
- Area-reduced alternative to the fully parallel sorter; same val/rdy message interface style as the other sort blocks.
- Sits between an upstream val/rdy producer and a downstream val/rdy consumer.

---
 rtl/sort_iter_pkg.sv | 34 +++
 rtl/sort_iter_minmax_sched_minmax.sv | 17 +
 rtl/sort_iter_minmax_sched.sv | 100 ++++++++++
 tb/tb_sort_iter_minmax_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sort_iter_pkg.sv
// Shared types and the fixed 5-step compare-swap schedule for the iterative 4-element sorter.
package sort_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_STEPS = 5;

  typedef logic [2:0] step_t;
  typedef logic [1:0] idx_t;

  typedef struct packed {
    idx_t a;
    idx_t b;
  } pair_t;

  // Optimal 4-input sorting network; a is always the lower index of the pair.
  function automatic pair_t step_pair(input step_t step);
    pair_t p;
    case (step)
      3'd0:    p = '{a: 2'd0, b: 2'd1};
      3'd1:    p = '{a: 2'd2, b: 2'd3};
      3'd2:    p = '{a: 2'd0, b: 2'd2};
      3'd3:    p = '{a: 2'd1, b: 2'd3};
      3'd4:    p = '{a: 2'd1, b: 2'd2};
      default: p = '{a: 2'd0, b: 2'd1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sort_iter_minmax_sched_minmax.sv
// Combinational unsigned min/max unit; on a tie, min is taken from input a.
module sort_iter_minmax_sched_minmax #(
  parameter int p_nbits = 8
) (
  input  logic [p_nbits-1:0] a,
  input  logic [p_nbits-1:0] b,
  output logic [p_nbits-1:0] mn,
  output logic [p_nbits-1:0] mx
);

  logic b_lt_a;

  assign b_lt_a = (b < a);
  assign mn     = b_lt_a ? b : a;
  assign mx     = b_lt_a ? a : b;

endmodule

// File: rtl/sort_iter_minmax_sched.sv
// Iterative 4-element sorter: one shared min/max unit stepped through a 5-step network.
// Define SORT_ITER_MINMAX_SCHED_DESCEND_EN for descending output (out0 = largest).
module sort_iter_minmax_sched
  import sort_iter_pkg::*;
#(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3
);

  state_t                   state_q, state_d;
  step_t                    step_q, step_d;
  logic [3:0][p_nbits-1:0]  r_q, r_d;

  pair_t                    pair_s;
  logic [p_nbits-1:0]       mm_a, mm_b, mm_min, mm_max;

  assign pair_s = step_pair(step_q);
  assign mm_a   = r_q[pair_s.a];
  assign mm_b   = r_q[pair_s.b];

  sort_iter_minmax_sched_minmax #(.p_nbits(p_nbits)) u_minmax (
    .a  (mm_a),
    .b  (mm_b),
    .mn (mm_min),
    .mx (mm_max)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (in_val) begin
          r_d[0]  = in0;
          r_d[1]  = in1;
          r_d[2]  = in2;
          r_d[3]  = in3;
          step_d  = '0;
          state_d = SORT;
        end
      end
      SORT: begin
`ifdef SORT_ITER_MINMAX_SCHED_DESCEND_EN
        r_d[pair_s.a] = mm_max;
        r_d[pair_s.b] = mm_min;
`else
        r_d[pair_s.a] = mm_min;
        r_d[pair_s.b] = mm_max;
`endif
        if (step_q == step_t'(NUM_STEPS - 1)) begin
          state_d = DONE;
        end else begin
          step_d = step_q + step_t'(1);
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      r_q     <= r_d;
    end
  end

  // Gated by reset so the block refuses messages while reset is still held.
  assign in_rdy  = (state_q == IDLE) && !reset;
  assign out_val = (state_q == DONE);
  assign out0    = r_q[0];
  assign out1    = r_q[1];
  assign out2    = r_q[2];
  assign out3    = r_q[3];

endmodule

// File: tb/tb_sort_iter_minmax_sched.sv
// Directed bench for sort_iter_minmax_sched: latency, ordering, ties, backpressure, throughput, async reset.
module tb_sort_iter_minmax_sched;

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in0, in1, in2, in3;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out0, out1, out2, out3;

  int n_tests;
  int n_fail;

  sort_iter_minmax_sched #(.p_nbits(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out0    (out0),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic logic [31:0] order(input logic [31:0] asc);
`ifdef SORT_ITER_MINMAX_SCHED_DESCEND_EN
    return {asc[7:0], asc[15:8], asc[23:16], asc[31:24]};
`else
    return asc;
`endif
  endfunction

  function automatic logic [31:0] outs();
    return {out0, out1, out2, out3};
  endfunction

  // Sends one message, checks 6-cycle latency and the sorted result; returns in the DONE cycle.
  task automatic run_msg(input string tag, input logic [31:0] vin, input logic [31:0] exp_asc);
    int cnt;
    cnt = 0;
    while (!in_rdy && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
    {in0, in1, in2, in3} = vin;
    in_val = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    {in0, in1, in2, in3} = 32'hA5A5_A5A5;
    check({tag, "_busy"}, 32'(in_rdy), 32'd0);
    cnt = 0;
    while (!out_val && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'd5);
    check({tag, "_data"}, outs(), order(exp_asc));
  endtask

  initial begin
    int cnt;
    logic [31:0] held;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    {in0, in1, in2, in3} = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_rdy", 32'(in_rdy), 32'd0);
    check("reset_out_val", 32'(out_val), 32'd0);
    check("reset_data", outs(), 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_rdy", 32'(in_rdy), 32'd1);

    run_msg("basic",    {8'd4, 8'd3, 8'd2, 8'd1},     {8'd1, 8'd2, 8'd3, 8'd4});
    run_msg("sorted",   {8'd1, 8'd2, 8'd3, 8'd4},     {8'd1, 8'd2, 8'd3, 8'd4});
    run_msg("dups",     {8'd5, 8'd5, 8'd0, 8'd5},     {8'd0, 8'd5, 8'd5, 8'd5});
    run_msg("extremes", {8'd255, 8'd0, 8'd255, 8'd0}, {8'd0, 8'd0, 8'd255, 8'd255});
    run_msg("mixed",    {8'd1, 8'd3, 8'd2, 8'd4},     {8'd1, 8'd2, 8'd3, 8'd4});

    // Backpressure: result must hold for 5 cycles while new input is offered and ignored.
    @(posedge clk); #1;
    out_rdy = 1'b0;
    run_msg("bp", {8'd200, 8'd10, 8'd100, 8'd50}, {8'd10, 8'd50, 8'd100, 8'd200});
    held = order({8'd10, 8'd50, 8'd100, 8'd200});
    in_val = 1'b1;
    {in0, in1, in2, in3} = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_val", 32'(out_val), 32'd1);
      check("bp_hold_rdy", 32'(in_rdy), 32'd0);
      check("bp_hold_data", outs(), held);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_release_val", 32'(out_val), 32'd0);
    check("bp_release_rdy", 32'(in_rdy), 32'd1);

    // Back-to-back with in_val held: second accept 7 cycles after the first.
    {in0, in1, in2, in3} = {8'd4, 8'd3, 8'd2, 8'd1};
    in_val = 1'b1;
    @(posedge clk); #1;
    {in0, in1, in2, in3} = {8'd9, 8'd8, 8'd7, 8'd6};
    cnt = 0;
    while (cnt < 20) begin
      cnt++;
      @(negedge clk);
      if (out_val) check("b2b_first_data", outs(), order({8'd1, 8'd2, 8'd3, 8'd4}));
      if (in_rdy) break;
    end
    check("b2b_interval", 32'(cnt), 32'd7);
    @(posedge clk); #1;
    in_val = 1'b0;
    {in0, in1, in2, in3} = 32'h5A5A_5A5A;
    cnt = 0;
    while (!out_val && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("b2b_second_latency", 32'(cnt), 32'd5);
    check("b2b_second_data", outs(), order({8'd6, 8'd7, 8'd8, 8'd9}));
    @(posedge clk); #1;

    // Async reset during step 2 abandons the message.
    {in0, in1, in2, in3} = {8'd40, 8'd30, 8'd20, 8'd10};
    in_val = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_out_val", 32'(out_val), 32'd0);
    check("arst_in_rdy", 32'(in_rdy), 32'd0);
    check("arst_data", outs(), 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_release_rdy", 32'(in_rdy), 32'd1);
    repeat (7) begin
      @(posedge clk); #1;
      if (out_val) check("arst_no_output", 32'(out_val), 32'd0);
    end
    run_msg("after_arst", {8'd3, 8'd1, 8'd2, 8'd0}, {8'd0, 8'd1, 8'd2, 8'd3});
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
